// File: rtl/pc_fetch_unit_pkg.sv
// Shared encodings for the LEGv8 fetch unit: PC-select codes, fetch states and fault causes.
// Also hosts the next-PC arithmetic so the top stays focused on sequencing.
package pc_fetch_unit_pkg;

    localparam int unsigned ADDR_W  = 64;
    localparam int unsigned INSTR_W = 32;

    typedef enum logic [1:0] {
        PS_HOLD = 2'b00,
        PS_INC  = 2'b01,
        PS_REG  = 2'b10,
        PS_REL  = 2'b11
    } ps_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WAIT  = 2'b01,
        ST_FAULT = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'b00,
        FAULT_MISALIGN = 2'b01,
        FAULT_TIMEOUT  = 2'b10
    } fault_e;

    // Relative branches are taken from the address of the instruction held in I, in word units.
    function automatic logic [ADDR_W-1:0] next_pc(
        input ps_e               ps,
        input logic [ADDR_W-1:0] pc,
        input logic [ADDR_W-1:0] reg_a,
        input logic [ADDR_W-1:0] instr_pc,
        input logic [ADDR_W-1:0] offset
    );
        logic [ADDR_W-1:0] result;
        case (ps)
            PS_INC:  result = pc + 64'd4;
            PS_REG:  result = reg_a;
            PS_REL:  result = instr_pc + (offset << 2);
            default: result = pc;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory read port: the fetch unit is the master, memory answers with rvalid/rdata.
interface pc_fetch_unit_if
    import pc_fetch_unit_pkg::*;
;
    logic               req;
    logic [ADDR_W-1:0]  addr;
    logic               rvalid;
    logic [INSTR_W-1:0] rdata;

    modport master (output req, addr, input rvalid, rdata);
    modport slave  (input req, addr, output rvalid, rdata);

endinterface

// File: rtl/pc_fetch_unit_timeout.sv
// Counts wait cycles of an outstanding fetch; terminal flags the last tolerated cycle.
// TIMEOUT of zero disables the terminal count entirely.
module fetch_timeout_counter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int unsigned WIDTH = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [WIDTH-1:0] count;

    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    generate
        if (TIMEOUT == 0) begin : g_disabled
            assign terminal = 1'b0;
        end else begin : g_enabled
            assign terminal = (count == WIDTH'(TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/pc_fetch_unit.sv
// Owns the PC and instruction register, fetching over the imem handshake and stalling the
// control unit while a fetch is outstanding. Faults are sticky until reset.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [1:0]           PS,
    input  logic                 IL,
    input  logic [ADDR_W-1:0]    constant,
    input  logic [ADDR_W-1:0]    reg_a,
    pc_fetch_unit_if.master      imem,
    output logic [INSTR_W-1:0]   I,
    output logic [ADDR_W-1:0]    pc,
    output logic [ADDR_W-1:0]    instr_pc,
    output logic                 stall,
    output logic                 fault,
    output logic [1:0]           fault_cause
);

    state_e state, next_state;
    logic   complete;
    logic   pc_update;
    logic   misaligned;
    logic   wait_enable;
    logic   wait_clear;
    logic   timeout_hit;

    fetch_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clock    (clock),
        .reset    (reset),
        .clear    (wait_clear),
        .enable   (wait_enable),
        .terminal (timeout_hit)
    );

    assign imem.addr  = pc;
    assign fault      = (state == ST_FAULT);
    assign wait_clear = complete || (state != ST_WAIT);

    // The PC only moves on cycles the control unit is not being held, so a misaligned
    // register target is caught at the same point the update would have happened.
    always_comb begin
        next_state  = state;
        imem.req    = 1'b0;
        stall       = 1'b0;
        complete    = 1'b0;
        wait_enable = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (IL) begin
                    imem.req = 1'b1;
                    if (imem.rvalid) begin
                        complete = 1'b1;
                    end else begin
                        stall      = 1'b1;
                        next_state = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                imem.req = 1'b1;
                stall    = ~imem.rvalid;
                if (imem.rvalid) begin
                    complete   = 1'b1;
                    next_state = ST_IDLE;
                end else begin
                    wait_enable = 1'b1;
                    if (timeout_hit) begin
                        next_state = ST_FAULT;
                    end
                end
            end
            ST_FAULT: begin
                stall = 1'b1;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
        pc_update  = !stall && (state != ST_FAULT);
        misaligned = pc_update && (ps_e'(PS) == PS_REG) && (reg_a[1:0] != 2'b00);
        if (misaligned) begin
            next_state = ST_FAULT;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= ST_IDLE;
            pc          <= RESET_PC;
            I           <= '0;
            instr_pc    <= '0;
            fault_cause <= FAULT_NONE;
        end else begin
            state <= next_state;
            if (complete) begin
                I        <= imem.rdata;
                instr_pc <= pc;
            end
            if (pc_update && !misaligned) begin
                pc <= next_pc(ps_e'(PS), pc, reg_a, instr_pc, constant);
            end
            if ((state != ST_FAULT) && (next_state == ST_FAULT)) begin
                fault_cause <= misaligned ? FAULT_MISALIGN : FAULT_TIMEOUT;
            end
        end
    end

endmodule
